// File: rtl/riscv_merge_pkg.sv
// Shared definitions for the two-input packet merge: arbiter states and port indices.
package riscv_merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic DATA_PORT  = 1'b0;
  localparam logic RISCV_PORT = 1'b1;

endpackage

// File: rtl/riscv_merge_slice.sv
// One-deep AXI-Stream output register; loads when ld is high and reports when it can accept.
module riscv_merge_slice #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                ld,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic [USER_W-1:0]   s_tuser,
  input  logic                s_tvalid,
  input  logic                s_tlast,
  output logic                rdy,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic [USER_W-1:0]   m_tuser,
  output logic                m_tvalid,
  output logic                m_tlast,
  input  logic                m_tready
);

  assign rdy = ~m_tvalid | m_tready;

  // Payload only changes with a real beat so an idle output keeps its last contents.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
    end else if (ld) begin
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
        m_tkeep <= s_tkeep;
        m_tuser <= s_tuser;
        m_tlast <= s_tlast;
      end
    end
  end

endmodule

// File: rtl/riscv_merge.sv
// Packet-atomic round-robin merge of the data-path stream and the RISC-V return stream.
module riscv_merge
  import riscv_merge_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s0_axis_tuser,
  input  logic                               s0_axis_tvalid,
  input  logic                               s0_axis_tlast,
  output logic                               s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s1_axis_tuser,
  input  logic                               s1_axis_tvalid,
  input  logic                               s1_axis_tlast,
  output logic                               s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic [31:0]                        pkt_cnt0,
  output logic [31:0]                        pkt_cnt1
);

  state_t      state_q;
  logic        last_grant_q;
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;

  logic sel;
  logic grant_act;
  logic rdy;
  logic acc0;
  logic acc1;

  logic [C_S_AXIS_DATA_WIDTH-1:0]   sel_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] sel_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  sel_tuser;
  logic                             sel_tlast;

  // In IDLE the grant follows the valids; inside a packet it is pinned to the owner.
  always_comb begin
    sel       = DATA_PORT;
    grant_act = 1'b1;
    case (state_q)
      ST_GRANT0: sel = DATA_PORT;
      ST_GRANT1: sel = RISCV_PORT;
      default: begin
        grant_act = s0_axis_tvalid | s1_axis_tvalid;
        if (s0_axis_tvalid && s1_axis_tvalid)
          sel = (last_grant_q == DATA_PORT) ? RISCV_PORT : DATA_PORT;
        else if (s1_axis_tvalid)
          sel = RISCV_PORT;
        else
          sel = DATA_PORT;
      end
    endcase
  end

  assign s0_axis_tready = aresetn & grant_act & rdy & (sel == DATA_PORT);
  assign s1_axis_tready = aresetn & grant_act & rdy & (sel == RISCV_PORT);
  assign acc0 = s0_axis_tvalid & s0_axis_tready;
  assign acc1 = s1_axis_tvalid & s1_axis_tready;

  assign sel_tdata = (sel == RISCV_PORT) ? s1_axis_tdata : s0_axis_tdata;
  assign sel_tkeep = (sel == RISCV_PORT) ? s1_axis_tkeep : s0_axis_tkeep;
  assign sel_tuser = (sel == RISCV_PORT) ? s1_axis_tuser : s0_axis_tuser;
  assign sel_tlast = (sel == RISCV_PORT) ? s1_axis_tlast : s0_axis_tlast;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= RISCV_PORT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc0) begin
            last_grant_q <= DATA_PORT;
            if (!s0_axis_tlast) state_q <= ST_GRANT0;
          end else if (acc1) begin
            last_grant_q <= RISCV_PORT;
            if (!s1_axis_tlast) state_q <= ST_GRANT1;
          end
        end
        ST_GRANT0: if (acc0 && s0_axis_tlast) state_q <= ST_IDLE;
        ST_GRANT1: if (acc1 && s1_axis_tlast) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt0_q <= 32'd0;
      cnt1_q <= 32'd0;
    end else begin
      if (acc0 && s0_axis_tlast) cnt0_q <= cnt0_q + 32'd1;
      if (acc1 && s1_axis_tlast) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

  riscv_merge_slice #(
    .DATA_W (C_S_AXIS_DATA_WIDTH),
    .USER_W (C_S_AXIS_TUSER_WIDTH)
  ) u_slice (
    .clk      (clk),
    .aresetn  (aresetn),
    .ld       (rdy),
    .s_tdata  (sel_tdata),
    .s_tkeep  (sel_tkeep),
    .s_tuser  (sel_tuser),
    .s_tvalid (acc0 | acc1),
    .s_tlast  (sel_tlast),
    .rdy      (rdy),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tuser  (m_axis_tuser),
    .m_tvalid (m_axis_tvalid),
    .m_tlast  (m_axis_tlast),
    .m_tready (m_axis_tready)
  );

endmodule

// File: doc/riscv_merge.md
RISCV_MERGE -- requirements
Module: riscv_merge

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 512, SHALL set the tdata width of all streams; tkeep width SHALL be C_S_AXIS_DATA_WIDTH/8.
REQ-002 Parameter C_S_AXIS_TUSER_WIDTH, default 128, SHALL set the tuser width of all streams.
REQ-003 clk  input  1  the single clock; all logic SHALL be rising-edge clocked.
REQ-004 aresetn  input  1  reset, asynchronous and active-low.
REQ-005 s0_axis_tdata/tkeep/tuser/tvalid/tlast  input  per params  data-path packet stream from the parser's m_axis.
REQ-006 s0_axis_tready  output  1  back-pressure to the data path.
REQ-007 s1_axis_tdata/tkeep/tuser/tvalid/tlast  input  per params  packets returned by the RISC-V core.
REQ-008 s1_axis_tready  output  1  back-pressure to the RISC-V return path.
REQ-009 m_axis_tdata/tkeep/tuser/tvalid/tlast  output  per params  merged stream, all registered.
REQ-010 m_axis_tready  input  1  downstream back-pressure.
REQ-011 pkt_cnt0, pkt_cnt1  output  32  packets forwarded from s0 and s1.

Function
REQ-012 The block SHALL be a packet-atomic two-input arbiter: beats of different packets SHALL never interleave on m_axis.
REQ-013 The FSM SHALL have states IDLE, GRANT0 and GRANT1.
REQ-014 In IDLE, the grant SHALL be decided combinationally:
- only one input valid: that input wins;
- both valid: the input other than last_grant wins (round robin).
REQ-015 The first beat of the winning input SHALL be accepted in the same IDLE cycle if the output register can load; the FSM then SHALL enter GRANTx.
REQ-016 The FSM SHALL return to IDLE in the cycle a beat with tlast=1 is accepted from the granted input.
- A single-beat packet SHALL leave the FSM in IDLE.
- Packets SHALL be forwarded back-to-back with no bubble.
REQ-017 The output register SHALL load when m_axis_tvalid=0 or m_axis_tready=1.
REQ-018 The tready of the granted input SHALL equal that load condition; the tready of the non-granted input SHALL be 0.
REQ-019 Latency SHALL be exactly 1 cycle from input acceptance to m_axis_tvalid.
REQ-020 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs SHALL hold stable.
REQ-021 last_grant SHALL update on acceptance of a packet's first beat.
REQ-022 pkt_cntX SHALL increment by 1 on each accepted tlast beat from sX and wrap from 0xFFFFFFFF to 0.
REQ-023 Input tvalid deasserting mid-packet SHALL insert output bubbles only; the grant SHALL be held until tlast.
REQ-024 tdata, tkeep and tuser SHALL pass through unmodified.

Reset
REQ-025 While aresetn=0: state=IDLE; last_grant=1; all m_axis outputs=0; s0/s1 tready=0; pkt_cnt0/pkt_cnt1=0.
REQ-026 Reset asserted mid-packet SHALL discard the partial packet; after release, arbitration SHALL restart in IDLE with s0 favoured.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings and the port indices DATA_PORT=0 and RISCV_PORT=1.
REQ-028 The output register SHALL be the sub-module riscv_merge_slice: a 1-deep AXI-Stream register taking the load enable and returning ready.

Verification
REQ-029 Bench SHALL cover: 3-beat packet on s0 only, m_axis_tready=1 -> 3 beats appear 1 cycle later, identical; pkt_cnt0=1.
REQ-030 Bench SHALL cover: s0 and s1 both valid from reset, 2-beat packets each -> s0 packet first, then s1 with no gap; pkt_cnt0=pkt_cnt1=1.
REQ-031 Bench SHALL cover: s1 raises valid mid s0 packet -> no s1 beat before the s0 tlast beat; s1_axis_tready=0 throughout the s0 packet.
REQ-032 Bench SHALL cover: m_axis_tready=0 for 5 cycles mid-packet -> output held stable; no beat lost or duplicated.
REQ-033 Bench SHALL cover: ten 1-beat packets on each input, both always valid -> strict s0/s1 alternation; pkt_cnt0=pkt_cnt1=10.
REQ-034 Bench SHALL cover: pkt_cnt0 preloaded to 0xFFFFFFFF -> reads 0 after the next s0 packet; aresetn pulsed mid-packet -> all outputs 0 and IDLE.
